// File: rtl/menshen_ram_pkg.sv
// Shared constants and helpers for the pipeline table RAMs.
package menshen_ram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int RDW_OLD    = 0;
  localparam int RDW_NEW    = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  function automatic int be_bits(input int data_bits);
    return (data_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Raw simple dual-port array: per-lane masked write, one-cycle registered read.
module sdp_ram_core #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 38,
  parameter int BE_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [BE_BITS-1:0]   wbe_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] wmask_s;
  logic [DATA_BITS-1:0] rdata_q;

  always_comb begin
    wmask_s = '0;
    for (int b = 0; b < DATA_BITS; b++) begin
      wmask_s[b] = wbe_i[b/8];
    end
  end

  // Array contents carry no reset; the top sweeps them instead.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_s) | (wdata_i & wmask_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdp_ram_pipe.sv
// Table RAM wrapper: post-reset clear sweep, traffic gating, read-during-write
// merge and configurable read latency with a matching valid pipeline.
module sdp_ram_pipe
  import menshen_ram_pkg::*;
#(
  parameter int  ADDR_BITS      = 5,
  parameter int  DATA_BITS      = 38,
  parameter int  RD_LATENCY     = 1,
  parameter int  RDW_NEW_DATA   = 0,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int BE_BITS        = be_bits(DATA_BITS)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [BE_BITS-1:0]   wr_be,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 init_done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR   = {ADDR_BITS{1'b1}};
  localparam ram_state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("sdp_ram_pipe: RD_LATENCY must be in 1..3");
  end
  if (RDW_NEW_DATA != RDW_OLD && RDW_NEW_DATA != RDW_NEW) begin : g_bad_rdw
    $error("sdp_ram_pipe: RDW_NEW_DATA must be 0 or 1");
  end

  ram_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                 init_done_q, init_done_d;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = RESET_STATE;
    endcase
    init_done_d = (state_d == ST_READY);
  end

  logic                 clearing_s, wr_fire_s, rd_fire_s;
  logic                 core_we_s;
  logic [ADDR_BITS-1:0] core_waddr_s;
  logic [DATA_BITS-1:0] core_wdata_s;
  logic [BE_BITS-1:0]   core_wbe_s;
  logic [DATA_BITS-1:0] core_rdata_s;

  assign clearing_s = (state_q == ST_CLEAR);
  assign wr_fire_s  = wr_en & init_done_q & aresetn;
  assign rd_fire_s  = rd_en & init_done_q & aresetn;

  // The sweep owns the write port until init_done rises.
  always_comb begin
    core_we_s = clearing_s | wr_fire_s;
    if (clearing_s) begin
      core_waddr_s = clr_cnt_q;
      core_wdata_s = '0;
      core_wbe_s   = '1;
    end else begin
      core_waddr_s = wr_addr;
      core_wdata_s = wr_data;
      core_wbe_s   = wr_be;
    end
  end

  sdp_ram_core #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .BE_BITS   (BE_BITS)
  ) u_core (
    .clk     (clk),
    .aresetn (aresetn),
    .we_i    (core_we_s),
    .waddr_i (core_waddr_s),
    .wdata_i (core_wdata_s),
    .wbe_i   (core_wbe_s),
    .re_i    (rd_fire_s),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata_s)
  );

  logic [BE_BITS-1:0]    coll_be_s, coll_be_q;
  logic [DATA_BITS-1:0]  coll_data_q;
  logic [DATA_BITS-1:0]  merged_s;
  logic [RD_LATENCY-1:0] vld_q;

  always_comb begin
    if (RDW_NEW_DATA == RDW_NEW && wr_fire_s && rd_fire_s && (rd_addr == wr_addr)) begin
      coll_be_s = wr_be;
    end else begin
      coll_be_s = '0;
    end
  end

  // Colliding write lanes travel beside the core read and patch it one cycle later.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      coll_be_q   <= '0;
      coll_data_q <= '0;
    end else if (rd_fire_s) begin
      coll_be_q   <= coll_be_s;
      coll_data_q <= wr_data;
    end
  end

  always_comb begin
    merged_s = core_rdata_s;
    for (int b = 0; b < DATA_BITS; b++) begin
      if (coll_be_q[b/8]) begin
        merged_s[b] = coll_data_q[b];
      end else begin
        merged_s[b] = core_rdata_s[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_fire_s;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data = merged_s;
  end else begin : g_latn
    logic [DATA_BITS-1:0] pipe_q [RD_LATENCY-1];

    // Each stage only advances with valid data so rd_data holds between reads.
    always_ff @(posedge clk) begin
      if (!aresetn) begin
        for (int k = 0; k < RD_LATENCY - 1; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        if (vld_q[0]) begin
          pipe_q[0] <= merged_s;
        end
        for (int k = 1; k < RD_LATENCY - 1; k++) begin
          if (vld_q[k]) begin
            pipe_q[k] <= pipe_q[k-1];
          end
        end
      end
    end

    assign rd_data = pipe_q[RD_LATENCY-2];
  end

  assign rd_valid  = vld_q[RD_LATENCY-1];
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Bench for sdp_ram_pipe: two instances (latency 1 / old-data and latency 3 /
// new-data) driven identically and compared against a behavioural table model.
module tb_sdp_ram_pipe;

  localparam int AB    = 5;
  localparam int DB    = 38;
  localparam int BB    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [AB-1:0] rd_addr = '0;
  logic [DB-1:0] wr_data = '0;
  logic [BB-1:0] wr_be = '0;
  logic [DB-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, init_done0, init_done1;

  always #5 clk = ~clk;

  sdp_ram_pipe #(.ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(1), .RDW_NEW_DATA(0),
                 .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .init_done(init_done0));

  sdp_ram_pipe #(.ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(3), .RDW_NEW_DATA(1),
                 .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_done(init_done1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    logic [DB-1:0] d;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DB-1:0] mem_m [DEPTH];
  logic [DB-1:0] last0 = '0;
  logic [DB-1:0] last1 = '0;
  int            cyc = 0;
  int            clr_left = 0;
  bit            init_m = 1'b0;
  bit            armed = 1'b0;

  function automatic logic [DB-1:0] lanes(input logic [DB-1:0] old, input logic [DB-1:0] nw,
                                          input logic [BB-1:0] be);
    logic [DB-1:0] r;
    r = old;
    for (int l = 0; l < BB; l++) begin
      if (be[l]) begin
        for (int b = 8 * l; b < 8 * l + 8 && b < DB; b++) r[b] = nw[b];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [DB-1:0] old_w, new_w;
    cyc++;
    if (!aresetn) begin
      armed    = 1'b1;
      init_m   = 1'b0;
      clr_left = DEPTH;
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (!init_m) begin
      clr_left--;
      if (clr_left == 0) begin
        init_m = 1'b1;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      end
    end else begin
      if (rd_en) begin
        old_w = mem_m[rd_addr];
        new_w = (wr_en && wr_addr == rd_addr) ? lanes(old_w, wr_data, wr_be) : old_w;
        q0.push_back('{cyc,     old_w});
        q1.push_back('{cyc + 2, new_w});
      end
      if (wr_en) mem_m[wr_addr] = lanes(mem_m[wr_addr], wr_data, wr_be);
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    exp_t e;
    bit   v0, v1;
    if (armed) begin
      chk("init_done0", 64'(init_done0), 64'(init_m));
      chk("init_done1", 64'(init_done1), 64'(init_m));
      v0 = (q0.size() > 0) && (q0[0].due == cyc);
      v1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("rd_valid0", 64'(rd_valid0), 64'(v0));
      chk("rd_valid1", 64'(rd_valid1), 64'(v1));
      if (v0) begin
        e = q0.pop_front();
        chk("rd_data0", 64'(rd_data0), 64'(e.d));
        last0 = e.d;
      end else begin
        chk("rd_hold0", 64'(rd_data0), 64'(last0));
      end
      if (v1) begin
        e = q1.pop_front();
        chk("rd_data1", 64'(rd_data1), 64'(e.d));
        last1 = e.d;
      end else begin
        chk("rd_hold1", 64'(rd_data1), 64'(last1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [DB-1:0] v [3];

    // Reset and clear sweep
    tick();
    tick();
    chk("rst_init_done", 64'(init_done0), 64'(1'b0));
    aresetn = 1'b1;
    wait_init(n);
    chk("sweep_len", 64'(n), 64'(32));
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = AB'(a);
      tick();
      chk("t1_zero", 64'(rd_data0), 64'(0));
    end
    idle();
    tick();
    tick();

    // Byte-lane write
    wr_en = 1'b1; wr_addr = AB'(3); wr_data = 38'h3F_FFFF_FFFF; wr_be = 5'b11111;
    tick();
    wr_be = 5'b00001; wr_data = '0;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = AB'(3);
    tick();
    idle();
    chk("t2_valid0", 64'(rd_valid0), 64'(1'b1));
    chk("t2_data0", 64'(rd_data0), 64'(38'h3F_FFFF_FF00));
    tick();
    tick();
    chk("t2_valid1", 64'(rd_valid1), 64'(1'b1));
    chk("t2_data1", 64'(rd_data1), 64'(38'h3F_FFFF_FF00));

    // Back-to-back reads through the three-stage instance
    v[0] = 38'h11_2233_4455;
    v[1] = 38'h2A_BCDE_F012;
    v[2] = 38'h05_A5A5_5A5A;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = AB'(i + 1); wr_data = v[i]; wr_be = 5'b11111;
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AB'(i + 1);
      tick();
      if (i < 2) chk("t3_early", 64'(rd_valid1), 64'(1'b0));
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid", 64'(rd_valid1), 64'(1'b1));
      chk("t3_data", 64'(rd_data1), 64'(v[i]));
      tick();
    end
    chk("t3_done", 64'(rd_valid1), 64'(1'b0));

    // Read-during-write collision on addr 7
    rd_en = 1'b1; rd_addr = AB'(7);
    wr_en = 1'b1; wr_addr = AB'(7); wr_data = 38'h55; wr_be = 5'b11111;
    tick();
    idle();
    chk("t4_old", 64'(rd_data0), 64'(0));
    tick();
    tick();
    chk("t4_new", 64'(rd_data1), 64'(38'h55));

    // Traffic during the sweep is dropped
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = AB'(9); wr_data = 38'hFF; wr_be = 5'b11111;
      rd_en = 1'b1; rd_addr = AB'(9);
      tick();
      chk("t5_novalid", 64'(rd_valid0), 64'(1'b0));
    end
    idle();
    wait_init(n);
    chk("t5_sweep", 64'(n), 64'(22));
    rd_en = 1'b1; rd_addr = AB'(9);
    tick();
    idle();
    chk("t5_valid", 64'(rd_valid0), 64'(1'b1));
    chk("t5_lost", 64'(rd_data0), 64'(0));
    tick();
    tick();

    // Reset with a read in flight, then again mid-sweep
    rd_en = 1'b1; rd_addr = AB'(3);
    tick();
    idle();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("t6_flush", 64'(rd_valid1), 64'(1'b0));
    for (int i = 0; i < 20; i++) tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    wait_init(n);
    chk("t6_restart", 64'(n), 64'(32));

    // Randomised traffic with frequent collisions
    for (int i = 0; i < 600; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = AB'($urandom_range(0, DEPTH - 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AB'($urandom_range(0, 7));
      wr_data = DB'({$urandom(), $urandom()});
      wr_be   = BB'($urandom_range(0, 31));
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
